// File: rtl/seg_scan_sched_if.sv
// rtl/seg_scan_sched_if.sv - digit source / display pin bundle for seg_scan_sched
interface seg_scan_sched_if;
  logic [31:0] digits_flat;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [3:0]  brightness;
  logic [6:0]  Seg;
  logic        DP;
  logic [7:0]  AN;
  logic        frame_tick;

  modport master (
    output digits_flat, digit_en, dp_in, brightness,
    input  Seg, DP, AN, frame_tick
  );

  modport slave (
    input  digits_flat, digit_en, dp_in, brightness,
    output Seg, DP, AN, frame_tick
  );
endinterface

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - 8-digit seven-segment scan scheduler with blanking and PWM
module seg_scan_sched #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  seg_scan_sched_if.slave   bus
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;
  localparam logic [0:0] ST_INIT  = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  logic [2:0]    r_idx;
  logic [CW-1:0] r_slot_cnt;
  logic [3:0]    r_pwm_cnt;
  logic [0:0]    r_state;
  logic [3:0]    r_val_snap;
  logic          r_en_snap;
  logic          r_dp_snap;
  logic [3:0]    r_bright_snap;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_tick;

  logic          w_slot_wrap;
  logic          w_slot_start;
  logic [CW-1:0] w_slot_nxt;
  logic [0:0]    w_state_nxt;
  logic [3:0]    w_pwm_nxt;
  logic [3:0]    w_val_live;
  logic [3:0]    w_val_eff;
  logic          w_en_eff;
  logic          w_dp_eff;
  logic [3:0]    w_bright_eff;
  logic          w_drive;
  logic [6:0]    w_seg_dec;

  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_slot_start = (r_slot_cnt == '0);
  assign w_slot_nxt   = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
  assign w_state_nxt  = (w_slot_nxt < BLANK_END) ? ST_BLANK : ST_ON;
  assign w_pwm_nxt    = (w_slot_nxt == BLANK_END) ? 4'd0 :
                        (r_state == ST_ON) ? r_pwm_cnt + 4'd1 : r_pwm_cnt;

  // The slot-start cycle uses the live inputs so a zero-length blank still lights correctly.
  assign w_val_live   = bus.digits_flat[{r_idx, 2'b00} +: 4];
  assign w_val_eff    = w_slot_start ? w_val_live          : r_val_snap;
  assign w_en_eff     = w_slot_start ? bus.digit_en[r_idx] : r_en_snap;
  assign w_dp_eff     = w_slot_start ? bus.dp_in[r_idx]    : r_dp_snap;
  assign w_bright_eff = w_slot_start ? bus.brightness      : r_bright_snap;

  assign w_drive = (r_state == ST_ON) && w_en_eff && (r_pwm_cnt < w_bright_eff);

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_val_eff)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx      <= 3'd0;
      r_slot_cnt <= '0;
      r_pwm_cnt  <= 4'd0;
      r_state    <= ST_INIT;
    end else begin
      r_slot_cnt <= w_slot_nxt;
      r_state    <= w_state_nxt;
      r_pwm_cnt  <= w_pwm_nxt;
      if (w_slot_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_val_snap    <= 4'd0;
      r_en_snap     <= 1'b0;
      r_dp_snap     <= 1'b0;
      r_bright_snap <= 4'd0;
    end else if (w_slot_start) begin
      r_val_snap    <= w_val_live;
      r_en_snap     <= bus.digit_en[r_idx];
      r_dp_snap     <= bus.dp_in[r_idx];
      r_bright_snap <= bus.brightness;
    end
  end

  // Seg and DP blank together with AN so no stale pattern ghosts across slots.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_an         <= 8'hFF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_drive ? ~(8'd1 << r_idx) : 8'hFF;
      r_seg        <= w_drive ? w_seg_dec : 7'h7F;
      r_dp         <= w_drive ? ~w_dp_eff : 1'b1;
      r_frame_tick <= w_slot_wrap && (r_idx == IDX_LAST);
    end
  end

  assign bus.AN         = r_an;
  assign bus.Seg        = r_seg;
  assign bus.DP         = r_dp;
  assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_sched.sv
// tb/tb_seg_scan_sched.sv - bench for seg_scan_sched with SCAN_DIV=20, BLANK_CYCLES=4
module tb_seg_scan_sched;
  localparam int SDIV = 20;
  localparam int BLK  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [7:0] m_an   = 8'hFF;
  logic [6:0] m_seg  = 7'h7F;
  logic       m_dp   = 1'b1;
  logic       m_tick = 1'b0;

  seg_scan_sched_if u_if();

  seg_scan_sched #(.SCAN_DIV(SDIV), .BLANK_CYCLES(BLK), .NUM_DIGITS(8)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (u_if)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: slot/phase arithmetic on the number of cycles since reset release.
  initial begin : model
    int n, s, sl;
    logic [3:0] sv, sb;
    logic se, sd, lit;
    n = 0; sv = 0; sb = 0; se = 0; sd = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        n = 0;
        m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_tick = 1'b0;
      end else begin
        s  = n % SDIV;
        sl = (n / SDIV) % 8;
        if (s == 0) begin
          sv = u_if.digits_flat[sl*4 +: 4];
          se = u_if.digit_en[sl];
          sd = u_if.dp_in[sl];
          sb = u_if.brightness;
        end
        lit    = (s >= BLK) && se && (((s - BLK) % 16) < int'(sb));
        m_an   = lit ? ~(8'd1 << sl) : 8'hFF;
        m_seg  = lit ? dec_tbl[sv] : 7'h7F;
        m_dp   = lit ? ~sd : 1'b1;
        m_tick = (s == SDIV - 1) && (sl == 7);
        n++;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_an",   u_if.AN,         8'hFF);
        chk("reset_seg",  u_if.Seg,        7'h7F);
        chk("reset_dp",   u_if.DP,         1'b1);
        chk("reset_tick", u_if.frame_tick, 1'b0);
      end else begin
        chk("model_an",   u_if.AN,         m_an);
        chk("model_seg",  u_if.Seg,        m_seg);
        chk("model_dp",   u_if.DP,         m_dp);
        chk("model_tick", u_if.frame_tick, m_tick);
      end
      chk("an_onehot", 32'($countones(~u_if.AN) <= 1), 1);
    end
  end

  task automatic setup(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p,
                       input logic [3:0] b);
    @(posedge clk); #1;
    rst = 1'b1;
    u_if.digits_flat = d; u_if.digit_en = e; u_if.dp_in = p; u_if.brightness = b;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    int lit_cnt, fe_cnt, fb_dp_cnt, bad_cnt, tick_cnt, tick1, tick2;
    logic [6:0] seg7;
    u_if.digits_flat = 32'hDEADBEEF; u_if.digit_en = 8'hFF;
    u_if.dp_in = 8'hA5; u_if.brightness = 4'h7;
    repeat (5) @(posedge clk);

    // Full scan at full brightness
    setup(32'h76543210, 8'hFF, 8'h00, 4'hF);
    repeat (4) @(posedge clk);
    @(negedge clk); chk("first_an_still_off", u_if.AN, 8'hFF);
    @(posedge clk);
    @(negedge clk); chk("first_an_low", u_if.AN, 8'hFE);
    chk("slot0_seg", u_if.Seg, 7'h40);
    lit_cnt = 0; tick_cnt = 0; tick1 = -1; tick2 = -1; seg7 = 7'h7F;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (i < 160 && u_if.AN != 8'hFF) lit_cnt++;
      if (u_if.AN == 8'h7F) seg7 = u_if.Seg;
      if (u_if.frame_tick) begin
        tick_cnt++;
        if (tick1 < 0) tick1 = i + 6; else tick2 = i + 6;
      end
    end
    chk("lit_per_frame", lit_cnt, 120);
    chk("slot7_seg", seg7, 7'h78);
    chk("tick_count", tick_cnt, 2);
    chk("first_tick_edge", tick1, 160);
    chk("tick_period", tick2 - tick1, 160);

    // Enable and DP masking
    setup(32'h76543210, 8'b0000_0101, 8'h04, 4'hF);
    fe_cnt = 0; fb_dp_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!(u_if.AN inside {8'hFF, 8'hFE, 8'hFB})) bad_cnt++;
      if (u_if.DP == 1'b0 && u_if.AN != 8'hFB) bad_cnt++;
      if (u_if.AN == 8'hFE) fe_cnt++;
      if (u_if.AN == 8'hFB && u_if.DP == 1'b0) fb_dp_cnt++;
    end
    chk("mask_bad", bad_cnt, 0);
    chk("mask_fe_cnt", fe_cnt, 30);
    chk("mask_fb_dp_cnt", fb_dp_cnt, 15);

    // Brightness extremes
    setup(32'h76543210, 8'hFF, 8'h00, 4'h0);
    lit_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (u_if.AN != 8'hFF) lit_cnt++;
    end
    chk("bright0_lit", lit_cnt, 0);
    setup(32'h76543210, 8'hFF, 8'h00, 4'h1);
    lit_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (u_if.AN != 8'hFF) lit_cnt++;
    end
    chk("bright1_lit", lit_cnt, 8);

    // Mid-slot input change is held off until the next visit
    setup(32'h76543210, 8'hFF, 8'h00, 4'hF);
    repeat (10) @(posedge clk);
    #1 u_if.digits_flat[3:0] = 4'h8;
    repeat (6) @(posedge clk);
    @(negedge clk); chk("midslot_an", u_if.AN, 8'hFE);
    chk("midslot_seg_held", u_if.Seg, 7'h40);
    repeat (150) @(posedge clk);
    @(negedge clk); chk("next_visit_an", u_if.AN, 8'hFE);
    chk("next_visit_seg", u_if.Seg, 7'h00);

    // Reset during slot 5 ON phase
    repeat (105) @(posedge clk);
    #1 chk("slot5_an", u_if.AN, 8'hDF);
    chk("slot5_seg", u_if.Seg, 7'h12);
    rst = 1'b1;
    #1 chk("async_reset_an", u_if.AN, 8'hFF);
    chk("async_reset_seg", u_if.Seg, 7'h7F);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("rerun_an_off", u_if.AN, 8'hFF);
    @(posedge clk);
    @(negedge clk); chk("rerun_first_an", u_if.AN, 8'hFE);
    repeat (60) @(posedge clk);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
